// File: rtl/shift_reg_pkg.sv
// Shared definitions for the ShiftReg family: operating-mode encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package shift_reg_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_HOLD = 2'd0,
    MODE_LOAD = 2'd1,
    MODE_SHL  = 2'd2,
    MODE_SHR  = 2'd3
  } mode_e;

endpackage

// File: rtl/shift_word_cnt.sv
// Modulo-MODULUS shift counter with load-clear and a registered wrap pulse.
// Latency: 1 cycle; cnt/wrap reflect the clr/inc sampled at the previous edge.
// Backpressure: none; clr/inc are acted on every cycle.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : force count to 0 and suppress wrap (takes priority over inc)
//   inc        : advance count by one, wrapping at MODULUS-1
//   cnt        : current count, 0..MODULUS-1
//   wrap       : high for the one cycle after the count wrapped
module shift_word_cnt
  import shift_reg_pkg::*;
#(
  parameter int MODULUS = 32,
  parameter int CNT_W   = (MODULUS > 1) ? $clog2(MODULUS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap
);

  // Explicit terminal compare so non-power-of-two moduli wrap correctly.
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MODULUS - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      wrap <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      wrap <= 1'b0;
    end else if (inc) begin
      if (cnt == LAST) begin
        cnt  <= '0;
        wrap <= 1'b1;
      end else begin
        cnt  <= cnt + CNT_W'(1);
        wrap <= 1'b0;
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: rtl/shift_reg_univ.sv
// Universal shift register (hold/load/shl/shr) with word counter; SERDES core.
// Latency: 1 cycle, every output is a flop; word_done marks the cycle after the WIDTH-th shift.
// Backpressure: none; a new operation is accepted every cycle.
//
// Optional feature: define SHIFT_REG_UNIV_ROTATE_EN to let rot=1 feed the
// outgoing bit back in on SHL/SHR. Without it rot is ignored.
//
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   mode                   : 0 HOLD, 1 LOAD, 2 SHL, 3 SHR
//   rot                    : rotate request (only with SHIFT_REG_UNIV_ROTATE_EN)
//   srl_in_lsb/srl_in_msb  : serial inputs entering at bit 0 (SHL) / bit WIDTH-1 (SHR)
//   prl_in                 : parallel load data
//   srl_out_msb/srl_out_lsb: register bit WIDTH-1 / bit 0
//   prl_out                : register contents
//   bit_cnt                : shifts since last LOAD or wrap
//   word_done              : one-cycle completed-word pulse
module shift_reg_univ
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [MODE_W-1:0]  mode,
  input  logic               rot,
  input  logic               srl_in_lsb,
  input  logic               srl_in_msb,
  input  logic [WIDTH-1:0]   prl_in,
  output logic               srl_out_msb,
  output logic               srl_out_lsb,
  output logic [WIDTH-1:0]   prl_out,
  output logic [CNT_W-1:0]   bit_cnt,
  output logic               word_done
);

  logic [WIDTH-1:0] data_q;
  logic             shl_in;
  logic             shr_in;
  logic             is_load;
  logic             is_shift;

`ifdef SHIFT_REG_UNIV_ROTATE_EN
  assign shl_in = rot ? data_q[WIDTH-1] : srl_in_lsb;
  assign shr_in = rot ? data_q[0]       : srl_in_msb;
`else
  assign shl_in = srl_in_lsb;
  assign shr_in = srl_in_msb;
  // rot stays on the port list so both builds share one interface.
  logic unused_rot;
  assign unused_rot = rot;
`endif

  assign is_load  = (mode_e'(mode) == MODE_LOAD);
  assign is_shift = (mode_e'(mode) == MODE_SHL) || (mode_e'(mode) == MODE_SHR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      case (mode_e'(mode))
        MODE_LOAD: data_q <= prl_in;
        MODE_SHL:  data_q <= {data_q[WIDTH-2:0], shl_in};
        MODE_SHR:  data_q <= {shr_in, data_q[WIDTH-1:1]};
        default:   data_q <= data_q;
      endcase
    end
  end

  // LOAD clears the counter, so a load in a would-be wrap cycle suppresses word_done.
  shift_word_cnt #(
    .MODULUS (WIDTH),
    .CNT_W   (CNT_W)
  ) u_word_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (is_load),
    .inc   (is_shift),
    .cnt   (bit_cnt),
    .wrap  (word_done)
  );

  assign prl_out     = data_q;
  assign srl_out_msb = data_q[WIDTH-1];
  assign srl_out_lsb = data_q[0];

endmodule

// File: tb/tb_shift_reg_univ.sv
// Bench for shift_reg_univ: a 32-bit and a 5-bit instance share one stimulus
// stream and are compared every cycle against a bit-vector reference model.
// Directed sequences cover reset, load/hold, serialise, deserialise, collision, rotate.
module tb_shift_reg_univ;

`ifdef SHIFT_REG_UNIV_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [1:0]  mode;
  logic        rot;
  logic        srl_in_lsb;
  logic        srl_in_msb;
  logic [31:0] prl_in;

  logic        srl_out_msb32, srl_out_lsb32, word_done32;
  logic [31:0] prl_out32;
  logic [4:0]  bit_cnt32;
  logic        srl_out_msb5, srl_out_lsb5, word_done5;
  logic [4:0]  prl_out5;
  logic [2:0]  bit_cnt5;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: register value, shifts since load/reset, last-cycle pulse.
  int          wd [2] = '{32, 5};
  logic [31:0] m_reg [2];
  int          m_tot [2];
  bit          m_done [2];

  shift_reg_univ #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .rot(rot),
    .srl_in_lsb(srl_in_lsb), .srl_in_msb(srl_in_msb), .prl_in(prl_in),
    .srl_out_msb(srl_out_msb32), .srl_out_lsb(srl_out_lsb32),
    .prl_out(prl_out32), .bit_cnt(bit_cnt32), .word_done(word_done32)
  );

  shift_reg_univ #(.WIDTH(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .rot(rot),
    .srl_in_lsb(srl_in_lsb), .srl_in_msb(srl_in_msb), .prl_in(prl_in[4:0]),
    .srl_out_msb(srl_out_msb5), .srl_out_lsb(srl_out_lsb5),
    .prl_out(prl_out5), .bit_cnt(bit_cnt5), .word_done(word_done5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] wmask(input int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_reg[k]  = '0;
      m_tot[k]  = 0;
      m_done[k] = 1'b0;
    end
  endtask

  task automatic model_apply(input logic [1:0] md, input logic r, input logic li,
                             input logic mi, input logic [31:0] p);
    for (int k = 0; k < 2; k++) begin
      int          w;
      logic [31:0] msk;
      logic        msb, lsb, fill;
      w    = wd[k];
      msk  = wmask(w);
      msb  = m_reg[k][w-1];
      lsb  = m_reg[k][0];
      case (md)
        2'd0: m_done[k] = 1'b0;
        2'd1: begin
          m_reg[k]  = p & msk;
          m_tot[k]  = 0;
          m_done[k] = 1'b0;
        end
        default: begin
          if (md == 2'd2) begin
            fill     = (ROT_EN && r) ? msb : li;
            m_reg[k] = ((m_reg[k] << 1) | 32'(fill)) & msk;
          end else begin
            fill     = (ROT_EN && r) ? lsb : mi;
            m_reg[k] = (m_reg[k] >> 1) | (32'(fill) << (w - 1));
          end
          m_tot[k]++;
          m_done[k] = ((m_tot[k] % w) == 0);
        end
      endcase
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".w32.prl"},  prl_out32,            m_reg[0]);
    check({tag, ".w32.msb"},  32'(srl_out_msb32),   32'(m_reg[0][31]));
    check({tag, ".w32.lsb"},  32'(srl_out_lsb32),   32'(m_reg[0][0]));
    check({tag, ".w32.cnt"},  32'(bit_cnt32),       32'(m_tot[0] % 32));
    check({tag, ".w32.done"}, 32'(word_done32),     32'(m_done[0]));
    check({tag, ".w5.prl"},   32'(prl_out5),        m_reg[1]);
    check({tag, ".w5.msb"},   32'(srl_out_msb5),    32'(m_reg[1][4]));
    check({tag, ".w5.lsb"},   32'(srl_out_lsb5),    32'(m_reg[1][0]));
    check({tag, ".w5.cnt"},   32'(bit_cnt5),        32'(m_tot[1] % 5));
    check({tag, ".w5.done"},  32'(word_done5),      32'(m_done[1]));
  endtask

  // Called at a negedge: drive, take one rising edge, compare at the next negedge.
  task automatic step(input string tag, input logic [1:0] md, input logic r,
                      input logic li, input logic mi, input logic [31:0] p);
    mode       = md;
    rot        = r;
    srl_in_lsb = li;
    srl_in_msb = mi;
    prl_in     = p;
    @(posedge clk);
    model_apply(md, r, li, mi, p);
    @(negedge clk);
    compare_all(tag);
  endtask

  // Asserts reset mid-cycle and checks outputs before any clock edge arrives.
  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int exp_cnt5 [10] = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0};

    rst_n = 1'b0; mode = 2'd0; rot = 1'b0;
    srl_in_lsb = 1'b0; srl_in_msb = 1'b0; prl_in = '0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all("reset");
    rst_n = 1'b1;

    // Asynchronous reset with the register full of ones.
    step("fill", 2'd1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF);
    check("fill_ones", prl_out32, 32'hFFFF_FFFF);
    async_reset("async_rst");
    check("async_rst_prl", prl_out32, 32'h0);

    // Load then hold.
    step("load", 2'd1, 1'b0, 1'b0, 1'b0, 32'hA5A5_0F0F);
    for (int i = 0; i < 5; i++) begin
      step("hold", 2'd0, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF);
      check("hold_prl", prl_out32, 32'hA5A5_0F0F);
      check("hold_done", 32'(word_done32), 32'h0);
    end

    // Serialise one 32-bit word out of the MSB end.
    step("ser_load", 2'd1, 1'b0, 1'b0, 1'b0, 32'h8000_0001);
    check("ser_msb_pre", 32'(srl_out_msb32), 32'h1);
    for (int i = 0; i < 32; i++) begin
      step("ser_shl", 2'd2, 1'b0, 1'b0, 1'b0, 32'h0);
      if (i == 0) check("ser_first", prl_out32, 32'h0000_0002);
      if (i < 31) check("ser_no_done", 32'(word_done32), 32'h0);
    end
    check("ser_done", 32'(word_done32), 32'h1);
    check("ser_cnt0", 32'(bit_cnt32), 32'h0);

    // Deserialise on the 5-bit instance: pulses after shifts 5 and 10.
    step("des_load", 2'd1, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 10; i++) begin
      step("des_shr", 2'd3, 1'b0, 1'b0, 1'b1, 32'h0);
      check("des_cnt", 32'(bit_cnt5), 32'(exp_cnt5[i]));
      check("des_done", 32'(word_done5), (i == 4 || i == 9) ? 32'h1 : 32'h0);
    end
    check("des_word", 32'(prl_out5), 32'h1F);

    // LOAD in the cycle that would otherwise wrap.
    step("col_load", 2'd1, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 31; i++)
      step("col_shift", (i % 2 == 0) ? 2'd2 : 2'd3, 1'b0, 1'b1, 1'b0, 32'h0);
    check("col_cnt31", 32'(bit_cnt32), 32'd31);
    step("col_hit", 2'd1, 1'b0, 1'b0, 1'b0, 32'h0000_1234);
    check("col_cnt", 32'(bit_cnt32), 32'h0);
    check("col_done", 32'(word_done32), 32'h0);
    check("col_prl", prl_out32, 32'h0000_1234);

    // Rotate right.
    step("rot_load", 2'd1, 1'b0, 1'b0, 1'b0, 32'h0000_0001);
    step("rot_shr", 2'd3, 1'b1, 1'b0, 1'b0, 32'h0);
    check("rot_prl", prl_out32, ROT_EN ? 32'h8000_0000 : 32'h0);

    // Randomized traffic, biased toward shifting, with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] md;
      md = ($urandom_range(0, 9) < 7) ? 2'(2 + $urandom_range(0, 1)) : 2'($urandom_range(0, 1));
      step("rand", md, 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
      if ($urandom_range(0, 299) == 0) async_reset("rand_rst");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/shift_reg_univ.md
# shift_reg_univ

Parametrised universal shift register: the successor to the fixed 32-bit serial/parallel shift register. It adds selectable width, four operating modes (hold, parallel load, shift left, shift right), independent serial ports at both ends, an optional rotate mode, and a shift counter that flags each completed word. It serves as the serialiser/deserialiser core for serial-link and scan-style blocks. Every output comes straight from a register, with no combinational input-to-output path.

## Interface
- `WIDTH`, default 32: register width in bits; legal range 2..1024.
- `CNT_W`, default `$clog2(WIDTH)`: shift-counter width. Derived; do not override.
- `clk`  in  1: single clock. All state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `mode`  in  2: operation select. 0 HOLD, 1 LOAD, 2 SHL, 3 SHR.
- `rot`  in  1: rotate request; only has an effect when `SHIFT_REG_UNIV_ROTATE_EN` is defined.
- `srl_in_lsb`  in  1: serial input, enters at bit 0 on SHL.
- `srl_in_msb`  in  1: serial input, enters at bit WIDTH-1 on SHR.
- `prl_in`  in  WIDTH: parallel load data.
- `srl_out_msb`  out  1: equals `prl_out[WIDTH-1]`; this bit leaves on SHL.
- `srl_out_lsb`  out  1: equals `prl_out[0]`; this bit leaves on SHR.
- `prl_out`  out  WIDTH: register contents.
- `bit_cnt`  out  CNT_W: number of shifts since the last LOAD or wrap, range 0..WIDTH-1.
- `word_done`  out  1: one-cycle pulse marking a completed word.

## Operation
- HOLD: register, `bit_cnt` and all state unchanged; `word_done` is driven 0.
- LOAD: register takes `prl_in`; `bit_cnt` is set to 0; `word_done` is driven 0.
- SHL: new register = {reg[WIDTH-2:0], in}, where in = `srl_in_lsb`, or reg[WIDTH-1] when rotating.
- SHR: new register = {in, reg[WIDTH-1:1]}, where in = `srl_in_msb`, or reg[0] when rotating.
- Counter on every shift (SHL or SHR):
  - If `bit_cnt` == WIDTH-1: `bit_cnt` wraps to 0 and `word_done` is set to 1 for the next cycle.
  - Otherwise: `bit_cnt` increments and `word_done` is driven 0.
- Switching direction mid-word does not reset the counter; shifts of either direction accumulate.
- LOAD in the same cycle a wrap would otherwise happen: LOAD wins, `bit_cnt` = 0, `word_done` = 0.
- Counter arithmetic is unsigned modulo WIDTH; for non-power-of-two WIDTH the wrap is an explicit compare, never natural overflow.
- Illegal modes: none; all four encodings are defined.

## Timing
- Reset values: `prl_out` = 0, `bit_cnt` = 0, `word_done` = 0, hence `srl_out_msb` = `srl_out_lsb` = 0.
- Reset is asynchronous assert, synchronous deassert (the synchroniser is external). Reset mid-word discards the partial word and clears the counter.
- Latency is one cycle: inputs sampled at edge N appear on `prl_out`, the serial outputs and `bit_cnt` after edge N.
- `word_done` is high for exactly the cycle after the WIDTH-th shift. In that cycle `prl_out` holds the completed word.
- Back-to-back continuous shifting gives a `word_done` pulse every WIDTH cycles, with no dead cycle.
- `rot` and `srl_in_*` are sampled only in the matching shift mode and are don't-care otherwise.

## Configuration
- `SHIFT_REG_UNIV_ROTATE_EN` defined: `rot` = 1 during SHL/SHR feeds the outgoing bit back in, as described above. The counter and `word_done` behave identically for rotates.
- Not defined: the `rot` port is still present but ignored; shifts always take `srl_in_*`. No rotate mux logic is synthesised.

## Structure
- Package `shift_reg_pkg` holds the `mode_e` enum (`MODE_HOLD`, `MODE_LOAD`, `MODE_SHL`, `MODE_SHR`) and its 2-bit width constant.
- The package is shared with future ShiftReg-family blocks.
- One sub-module, `shift_word_cnt`: the modulo-WIDTH counter with load-clear, increment enable and registered wrap pulse. It is parametrised by MODULUS.
- The data path stays in the top module.

## Test plan
- Reset: drive `rst_n` = 0 asynchronously mid-cycle with `prl_out` = 0xFFFF_FFFF -> all outputs 0 immediately, without waiting for a clock edge.
- Load then hold: LOAD 0xA5A5_0F0F, then HOLD for 5 cycles -> `prl_out` = 0xA5A5_0F0F and `bit_cnt` = 0 throughout; `word_done` never asserts.
- Serialise: LOAD 0x8000_0001, then 32×SHL with `srl_in_lsb` = 0:
  - `srl_out_msb` = 1 before the first shift.
  - `prl_out` = 0x0000_0002 after the first shift.
  - `word_done` pulses in the cycle after the 32nd shift, `bit_cnt` = 0.
- Deserialise with WIDTH = 5 (non-power-of-two): 10×SHR with `srl_in_msb` = 1 ->
  - `word_done` pulses after shift 5 and after shift 10;
  - `bit_cnt` follows the sequence 1, 2, 3, 4, 0.
- Collision: shift to `bit_cnt` = 31, then apply LOAD 0x1234 -> `bit_cnt` = 0, `word_done` = 0, `prl_out` = 0x1234.
- Rotate, with the macro defined: LOAD 0x0000_0001, SHR with `rot` = 1 -> `prl_out` = 0x8000_0000. The same stimulus with the macro undefined and `srl_in_msb` = 0 -> `prl_out` = 0.
